// File: rtl/logs_nco_pkg.sv
// Shared definitions for the multi-channel square/pulse NCO.
//   - MODE_SQUARE / MODE_PULSE : per-channel waveform mode encoding
//   - state_e                  : sweep FSM state
//   - reset_duty()             : reset value of the pulse threshold, 2^(n-1)
package logs_nco_pkg;

  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  // Half-scale threshold, so a freshly reset pulse channel has 50% duty.
  function automatic logic [31:0] reset_duty(input int unsigned n);
    return 32'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/logs_nco_wave.sv
// Combinational waveform shaper for one channel.
//   phase_i : current (pre-add) phase accumulator value
//   duty_i  : pulse threshold, used in pulse mode only
//   mode_i  : MODE_SQUARE -> phase MSB, MODE_PULSE -> (phase < duty)
//   wave_o  : 1-bit waveform sample
module logs_nco_wave
  import logs_nco_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] phase_i,
  input  logic [N-1:0] duty_i,
  input  logic         mode_i,
  output logic         wave_o
);

  always_comb begin
    if (mode_i == MODE_PULSE) begin
      wave_o = (phase_i < duty_i);
    end else begin
      wave_o = phase_i[N-1];
    end
  end

endmodule

// File: rtl/logs_nco_multi.sv
// Multi-channel square/pulse NCO. CHANNELS phase accumulators share a single
// adder and waveform shaper; a step pulse starts a sweep that updates one
// channel per clock, channel 0 first.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   step                 : start one sweep (ignored and flagged while busy)
//   wr_en/wr_chan        : config write strobe and target channel
//   wr_freq/duty/mode    : new increment, pulse threshold, waveform mode
//   wr_sync              : with wr_en, clear the target channel's phase
//   ovr_clr              : clear the sticky overrun flag
//   busy, overrun        : sweep in progress, step arrived while busy
//   snd                  : per-channel waveform
//   mix                  : registered popcount(snd), only with LOGS_NCO_MIX_EN
module logs_nco_multi
  import logs_nco_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned MW      = $clog2(CHANNELS + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                step,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_chan,
  input  logic [N-2:0]        wr_freq,
  input  logic [N-1:0]        wr_duty,
  input  logic                wr_mode,
  input  logic                wr_sync,
  input  logic                ovr_clr,
  output logic                busy,
  output logic                overrun,
`ifdef LOGS_NCO_MIX_EN
  output logic [MW-1:0]       mix,
`endif
  output logic [CHANNELS-1:0] snd
);

  localparam logic [N-1:0] DutyRst = N'(reset_duty(N));

  logic [N-1:0]  phase_q [CHANNELS];
  logic [N-1:0]  phase_d [CHANNELS];
  logic [N-2:0]  freq_q  [CHANNELS];
  logic [N-2:0]  freq_d  [CHANNELS];
  logic [N-1:0]  duty_q  [CHANNELS];
  logic [N-1:0]  duty_d  [CHANNELS];
  logic          mode_q  [CHANNELS];
  logic          mode_d  [CHANNELS];

  logic [CHANNELS-1:0] snd_q, snd_d;
  state_e              state_q, state_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic                overrun_q, overrun_d;

  logic          active;
  logic          wr_hit;
  logic [N-1:0]  cur_phase;
  logic [N-1:0]  sum;
  logic          wave_bit;

  assign active    = (state_q == StRun);
  assign wr_hit    = wr_en && (32'(wr_chan) < CHANNELS);
  assign cur_phase = phase_q[idx_q];
  assign sum       = cur_phase + {1'b0, freq_q[idx_q]};

  logs_nco_wave #(
    .N (N)
  ) u_wave (
    .phase_i (cur_phase),
    .duty_i  (duty_q[idx_q]),
    .mode_i  (mode_q[idx_q]),
    .wave_o  (wave_bit)
  );

  always_comb begin
    phase_d   = phase_q;
    freq_d    = freq_q;
    duty_d    = duty_q;
    mode_d    = mode_q;
    snd_d     = snd_q;
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (step) begin
          state_d = StRun;
          idx_d   = '0;
        end
      end
      StRun: begin
        // Shaper and adder both see the pre-add phase and the old config.
        snd_d[idx_q]   = wave_bit;
        phase_d[idx_q] = sum;
        if (idx_q == CW'(CHANNELS - 1)) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase

    // Set has priority over clear.
    if (ovr_clr) overrun_d = 1'b0;
    if (active && step) overrun_d = 1'b1;

    // Applied last so a sync on the active channel overrides the add.
    if (wr_hit) begin
      freq_d[wr_chan] = wr_freq;
      duty_d[wr_chan] = wr_duty;
      mode_d[wr_chan] = wr_mode;
      if (wr_sync) phase_d[wr_chan] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        phase_q[c] <= '0;
        freq_q[c]  <= '0;
        duty_q[c]  <= DutyRst;
        mode_q[c]  <= MODE_SQUARE;
      end
      snd_q     <= '0;
      state_q   <= StIdle;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      freq_q    <= freq_d;
      duty_q    <= duty_d;
      mode_q    <= mode_d;
      snd_q     <= snd_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy    = active;
  assign overrun = overrun_q;
  assign snd     = snd_q;

`ifdef LOGS_NCO_MIX_EN
  logic [MW-1:0] mix_q, mix_d;

  always_comb begin
    mix_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      mix_d = mix_d + MW'(snd_q[c]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mix_q <= '0;
    end else begin
      mix_q <= mix_d;
    end
  end

  assign mix = mix_q;
`endif

endmodule

// File: tb/tb_logs_nco_multi.sv
// Self-checking bench for logs_nco_multi with N=5, CHANNELS=3.
// Build with LOGS_NCO_MIX_EN defined to also check the mix output.
module tb_logs_nco_multi;

  localparam int unsigned N  = 5;
  localparam int unsigned CH = 3;

  logic       clk;
  logic       reset_n;
  logic       step;
  logic       wr_en;
  logic [1:0] wr_chan;
  logic [3:0] wr_freq;
  logic [4:0] wr_duty;
  logic       wr_mode;
  logic       wr_sync;
  logic       ovr_clr;
  logic       busy;
  logic       overrun;
  logic [2:0] snd;
`ifdef LOGS_NCO_MIX_EN
  logic [1:0] mix;
`endif

  int total = 0;
  int bad   = 0;

  logs_nco_multi #(
    .N        (N),
    .CHANNELS (CH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (step),
    .wr_en   (wr_en),
    .wr_chan (wr_chan),
    .wr_freq (wr_freq),
    .wr_duty (wr_duty),
    .wr_mode (wr_mode),
    .wr_sync (wr_sync),
    .ovr_clr (ovr_clr),
    .busy    (busy),
    .overrun (overrun),
`ifdef LOGS_NCO_MIX_EN
    .mix     (mix),
`endif
    .snd     (snd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit wr;
    int chan;
    int freq;
    int duty;
    bit mode;
    int nsteps;
    int exp_snd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit wr, int chan, int freq, int duty, bit mode, int ns, int es);
    vec_t v;
    v.wr = wr; v.chan = chan; v.freq = freq; v.duty = duty; v.mode = mode;
    v.nsteps = ns; v.exp_snd = es;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic cfg(input int chan, input int freq, input int duty, input bit mode,
                     input bit sync);
    wr_en = 1'b1; wr_chan = 2'(chan); wr_freq = 4'(freq); wr_duty = 5'(duty);
    wr_mode = mode; wr_sync = sync;
    tick();
    wr_en = 1'b0; wr_sync = 1'b0;
  endtask

  // One sweep; optionally a config write lands on the edge that processes at_c.
  task automatic sweep_wr(input bit wr, input int at_c, input int chan, input int freq,
                          input int duty, input bit mode, input bit sync);
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int c = 0; c < int'(CH); c++) begin
      if (wr && c == at_c) begin
        wr_en = 1'b1; wr_chan = 2'(chan); wr_freq = 4'(freq); wr_duty = 5'(duty);
        wr_mode = mode; wr_sync = sync;
      end
      tick();
      wr_en = 1'b0; wr_sync = 1'b0;
    end
    tick();
  endtask

  task automatic sweep();
    sweep_wr(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; step = 1'b0; wr_en = 1'b0; wr_chan = '0; wr_freq = '0;
    wr_duty = '0; wr_mode = 1'b0; wr_sync = 1'b0; ovr_clr = 1'b0;
    #12 reset_n = 1'b1;
    tick();

    chk("reset busy", int'(busy), 0);
    chk("reset overrun", int'(overrun), 0);
    chk("reset snd", int'(snd), 0);
`ifdef LOGS_NCO_MIX_EN
    chk("reset mix", int'(mix), 0);
`endif

    // Square on ch0 (freq 4), then pulse on ch1 (freq 1, duty 8, then duty 0).
    vecs.push_back(mk(1, 0, 4, 16, 0, 1, 3'b000));  // step 1
    vecs.push_back(mk(0, 0, 0, 0,  0, 3, 3'b000));  // step 4
    vecs.push_back(mk(0, 0, 0, 0,  0, 1, 3'b001));  // step 5
    vecs.push_back(mk(0, 0, 0, 0,  0, 3, 3'b001));  // step 8
    vecs.push_back(mk(0, 0, 0, 0,  0, 1, 3'b000));  // step 9
    vecs.push_back(mk(0, 0, 0, 0,  0, 3, 3'b000));  // step 12
    vecs.push_back(mk(0, 0, 0, 0,  0, 1, 3'b001));  // step 13
    vecs.push_back(mk(0, 0, 0, 0,  0, 3, 3'b001));  // step 16, ch0 phase wraps to 0
    vecs.push_back(mk(1, 0, 0, 16, 0, 0, 3'b001));  // freeze ch0, snd unchanged
    vecs.push_back(mk(1, 1, 1, 8,  1, 1, 3'b010));  // ch1 step 1
    vecs.push_back(mk(0, 0, 0, 0,  0, 7, 3'b010));  // ch1 step 8
    vecs.push_back(mk(0, 0, 0, 0,  0, 1, 3'b000));  // ch1 step 9
    vecs.push_back(mk(0, 0, 0, 0,  0, 23, 3'b000)); // ch1 step 32
    vecs.push_back(mk(1, 1, 1, 0,  1, 1, 3'b000));  // duty 0
    vecs.push_back(mk(0, 0, 0, 0,  0, 5, 3'b000));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) cfg(vecs[i].chan, vecs[i].freq, vecs[i].duty, vecs[i].mode, 1'b0);
      for (int s = 0; s < vecs[i].nsteps; s++) sweep();
      chk($sformatf("vec%0d snd", i), int'(snd), vecs[i].exp_snd);
    end

    // Sweep timing and overrun: all channels pulse, phase 0 -> each snd goes to 1.
    do_reset();
    for (int c = 0; c < int'(CH); c++) cfg(c, 0, 16, 1'b1, 1'b0);
    step = 1'b1;
    tick();                               // step edge
    chk("t0 busy", int'(busy), 1);
    chk("t0 snd", int'(snd), 3'b000);
    chk("t0 overrun", int'(overrun), 0);
    tick();                               // second step sampled here while busy
    step = 1'b0;
    chk("t1 busy", int'(busy), 1);
    chk("t1 snd", int'(snd), 3'b001);
    chk("t1 overrun", int'(overrun), 1);
    tick();
    chk("t2 busy", int'(busy), 1);
    chk("t2 snd", int'(snd), 3'b011);
`ifdef LOGS_NCO_MIX_EN
    chk("t2 mix", int'(mix), 1);
`endif
    tick();
    chk("t3 busy", int'(busy), 0);
    chk("t3 snd", int'(snd), 3'b111);
`ifdef LOGS_NCO_MIX_EN
    chk("t3 mix", int'(mix), 2);
`endif
    tick();
    chk("t4 busy no restart", int'(busy), 0);
    chk("t4 overrun held", int'(overrun), 1);
`ifdef LOGS_NCO_MIX_EN
    chk("t4 mix", int'(mix), 3);
`endif
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr", int'(overrun), 0);
    step = 1'b1;
    tick();
    ovr_clr = 1'b1;                       // clear and new overrun together
    tick();
    step = 1'b0; ovr_clr = 1'b0;
    chk("ovr set wins", int'(overrun), 1);
    repeat (4) tick();

    // Writes landing on the channel active in the same cycle.
    do_reset();
    cfg(1, 3, 2, 1'b1, 1'b0);
    sweep();                                      // wave(0)=1, phase 3
    chk("act s1", int'(snd), 3'b010);
    sweep_wr(1'b1, 1, 1, 5, 2, 1'b1, 1'b1);       // wave(3)=0, sync -> 0
    chk("act s2 pre-clear", int'(snd), 3'b000);
    sweep();                                      // wave(0)=1, phase 5
    chk("act s3 synced", int'(snd), 3'b010);
    sweep();                                      // wave(5)=0, phase 10
    chk("act s4", int'(snd), 3'b000);
    sweep_wr(1'b1, 1, 1, 1, 12, 1'b1, 1'b0);      // old duty 2: wave(10)=0, old add -> 15
    chk("act s5 old duty", int'(snd), 3'b000);
    sweep();                                      // 15 < 12 false
    chk("act s6 old freq", int'(snd), 3'b000);
    cfg(3, 7, 31, 1'b1, 1'b1);                    // out of range: ignored
    sweep();                                      // ch1 phase 16 -> 0
    chk("bad chan", int'(snd), 3'b000);

    // Asynchronous reset mid-sweep.
    cfg(0, 0, 31, 1'b1, 1'b0);
    sweep();
    chk("pre-rst snd", int'(snd), 3'b001);
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    chk("pre-rst busy", int'(busy), 1);
    chk("pre-rst overrun", int'(overrun), 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid-rst busy", int'(busy), 0);
    chk("mid-rst snd", int'(snd), 0);
    chk("mid-rst overrun", int'(overrun), 0);
`ifdef LOGS_NCO_MIX_EN
    chk("mid-rst mix", int'(mix), 0);
`endif
    #2;
    reset_n = 1'b1;
    tick();
    chk("post-rst busy", int'(busy), 0);
    cfg(1, 0, 1, 1'b1, 1'b0);
    sweep();                                      // ch1 phase 0 < 1; ch0 back to square
    chk("post-rst phases", int'(snd), 3'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
